ttl_schmitt_nand_filt: RTL



---
 rtl/ttl_schmitt_nand_filt.sv | 76 +++++++
 1 files changed

// File: rtl/ttl_schmitt_nand_filt.sv
// Multi-channel clocked Schmitt-trigger NAND/AND gate: synchronised inputs feed a
// saturating up/down integrator whose separate thresholds give hysteresis in cycles.
module ttl_schmitt_nand_filt #(
    parameter int CH    = 4,
    parameter int NIN   = 4,
    parameter int CW    = 4,
    parameter int TH_HI = 12,
    parameter int TH_LO = 3,
    parameter int INV   = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic [CH*NIN-1:0]   a,
    output logic [CH-1:0]       y,
    output logic [CH-1:0]       chg
);

    localparam int             MAX     = (1 << CW) - 1;
    localparam logic [CW-1:0]  CNT_MAX = '1;
    localparam logic [CW-1:0]  CNT_HI  = CW'(TH_HI);
    localparam logic [CW-1:0]  CNT_LO  = CW'(TH_LO);

    if (TH_LO < 0 || TH_LO >= TH_HI || TH_HI > MAX || CH < 1 || NIN < 1 || CW < 2) begin : g_param_err
        $error("ttl_schmitt_nand_filt: illegal parameters (need 0 <= TH_LO < TH_HI <= 2^CW-1, CH>=1, NIN>=1, CW>=2)");
    end

    for (genvar c = 0; c < CH; c++) begin : g_ch
        logic [NIN-1:0] s1_q, s2_q;
        logic           raw;
        logic [CW-1:0]  cnt_q, cnt_d;
        logic           y_q, y_d;
        logic           chg_q, chg_d;

        // Thresholds are compared against the next count so y moves on the crossing edge.
        always_comb begin
            raw   = (INV != 0) ? ~&s2_q : &s2_q;
            cnt_d = cnt_q;
            y_d   = y_q;
            chg_d = 1'b0;
            if (en) begin
                if (raw && cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + CW'(1);
                end else if (!raw && cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end
                if (!y_q && cnt_d >= CNT_HI) begin
                    y_d = 1'b1;
                end else if (y_q && cnt_d <= CNT_LO) begin
                    y_d = 1'b0;
                end
                chg_d = y_d ^ y_q;
            end
        end

        always_ff @(posedge clk) begin
            if (rst) begin
                s1_q  <= '0;
                s2_q  <= '0;
                cnt_q <= '0;
                y_q   <= 1'b0;
                chg_q <= 1'b0;
            end else begin
                s1_q  <= a[c*NIN +: NIN];
                s2_q  <= s1_q;
                cnt_q <= cnt_d;
                y_q   <= y_d;
                chg_q <= chg_d;
            end
        end

        assign y[c]   = y_q;
        assign chg[c] = chg_q;
    end

endmodule
